// File: rtl/div_pkg.sv
// div_pkg: shared types and constants for the sequential divider
package div_pkg;
    typedef enum logic [1:0] {DIV = 2'b00, DIVU = 2'b01, REM = 2'b10, REMU = 2'b11} div_op_t;
    typedef enum logic [1:0] {IDLE = 2'b00, CALC = 2'b01, FIN = 2'b10} div_state_t;
    localparam int DIV_W = 32;
    localparam int CNT_W = $clog2(DIV_W);
endpackage

// File: rtl/div_restore_step.sv
// div_restore_step: one restoring shift/trial-subtract/select iteration
module div_restore_step #(
    parameter int W = 32
) (
    input  logic [W-1:0] rem,
    input  logic [W-1:0] quo,
    input  logic [W-1:0] dmag,
    output logic [W-1:0] rem_n,
    output logic [W-1:0] quo_n
);
    logic [W:0] shifted;
    logic [W:0] trial;
    // keep the bit shifted out of rem so divisors >= 2^(W-1) still compare correctly
    assign shifted = {rem, quo[W-1]};
    assign trial   = shifted - {1'b0, dmag};
    assign rem_n   = trial[W] ? shifted[W-1:0] : trial[W-1:0];
    assign quo_n   = {quo[W-2:0], ~trial[W]};
endmodule

// File: rtl/seq_divider_32bit.sv
// seq_divider_32bit: iterative radix-2 restoring divider for RV32IM DIV/DIVU/REM/REMU
module seq_divider_32bit
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);
    div_state_t       state;
    div_op_t          op_c;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] rem, quo, dmag, rem_n, quo_n, a_mag, b_mag;
    logic             is_rem, neg_q, neg_r, sgn, a_neg, b_neg, dz, ovf;
    assign op_c  = div_op_t'(op);
    assign sgn   = op_c == DIV || op_c == REM;
    assign a_neg = sgn & dividend[WIDTH-1];
    assign b_neg = sgn & divisor[WIDTH-1];
    assign a_mag = a_neg ? -dividend : dividend;
    assign b_mag = b_neg ? -divisor : divisor;
    assign dz    = divisor == '0;
    assign ovf   = sgn && dividend == {1'b1, {(WIDTH-1){1'b0}}} && divisor == '1;
    assign busy  = state != IDLE;
    div_restore_step #(.W(WIDTH)) u_step (
        .rem  (rem),
        .quo  (quo),
        .dmag (dmag),
        .rem_n(rem_n),
        .quo_n(quo_n)
    );
    // special cases preload quo/rem with the final answer and skip CALC;
    // abs(MIN) == MIN, so the overflow quotient falls out of a_mag directly
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            rem    <= '0;
            quo    <= '0;
            dmag   <= '0;
            is_rem <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            result <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    is_rem <= op_c == REM || op_c == REMU;
                    neg_q  <= (a_neg ^ b_neg) & ~dz;
                    neg_r  <= a_neg & ~dz;
                    dmag   <= b_mag;
                    cnt    <= CNT_W'(WIDTH - 1);
                    rem    <= dz ? dividend : '0;
                    quo    <= dz ? '1 : a_mag;
                    state  <= (dz || ovf) ? FIN : CALC;
                end
                CALC: begin
                    rem   <= rem_n;
                    quo   <= quo_n;
                    cnt   <= cnt - 1'b1;
                    state <= cnt == '0 ? FIN : CALC;
                end
                FIN: begin
                    result <= is_rem ? (neg_r ? -rem : rem) : (neg_q ? -quo : quo);
                    done   <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
